// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state type and address-phase error check
// for the on-chip SRAM responder.
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  // Only full 32-bit beats with FIXED or INCR addressing are served.
  function automatic logic addr_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst == BURST_WRAP);
  endfunction
endpackage

// File: rtl/cmn_ram.sv
// Single-port synchronous RAM with byte write enables and a registered read.
// The read register is reset so the read data bus starts at zero.
module cmn_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            rd_en_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata_q <= '0;
    else if (rd_en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave serving single and burst transfers from an on-chip scratch RAM.
// Handshakes: a transfer happens on any rising clk edge where valid & ready are both 1.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DEPTH_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);
  state_t             state_q, state_d;
  logic               last_wr_q, last_wr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic               fixed_q, fixed_d;
  logic               err_q, err_d;

  logic [DEPTH_W-1:0] ram_addr, addr_nxt;
  logic [3:0]         ram_be;
  logic               ram_rd;
  logic               beat_last, wr_err;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_W-1:DEPTH_W+2], s_axi_awaddr[1:0],
                              s_axi_araddr[ADDR_W-1:DEPTH_W+2], s_axi_araddr[1:0]};

  assign beat_last = (cnt_q == len_q);
  assign addr_nxt  = fixed_q ? addr_q : addr_q + 1'b1;
  assign wr_err    = err_q | (s_axi_wlast != beat_last);

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    fixed_d   = fixed_q;
    err_d     = err_q;
    ram_addr  = addr_q;
    ram_be    = '0;
    ram_rd    = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = RESP_OKAY;
    case (state_q)
      IDLE: begin
        // Ties alternate: last_wr_q hands the next contested grant to the other side.
        s_axi_awready = !rst && !(s_axi_arvalid && last_wr_q);
        s_axi_arready = !rst && !(s_axi_awvalid && !last_wr_q);
        if (s_axi_awvalid && s_axi_awready) begin
          state_d   = WRITE;
          last_wr_d = 1'b1;
          id_d      = s_axi_awid;
          len_d     = s_axi_awlen;
          cnt_d     = '0;
          addr_d    = s_axi_awaddr[DEPTH_W+1:2];
          fixed_d   = (s_axi_awburst == BURST_FIXED);
          err_d     = addr_err(s_axi_awsize, s_axi_awburst);
        end else if (s_axi_arvalid && s_axi_arready) begin
          state_d   = READ;
          last_wr_d = 1'b0;
          id_d      = s_axi_arid;
          len_d     = s_axi_arlen;
          cnt_d     = '0;
          addr_d    = s_axi_araddr[DEPTH_W+1:2];
          fixed_d   = (s_axi_arburst == BURST_FIXED);
          err_d     = addr_err(s_axi_arsize, s_axi_arburst);
          ram_addr  = s_axi_araddr[DEPTH_W+1:2];
          ram_rd    = 1'b1;
        end
      end
      WRITE: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          err_d  = wr_err;
          ram_be = wr_err ? 4'h0 : s_axi_wstrb;
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) state_d = WRESP;
        end
      end
      WRESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) state_d = IDLE;
      end
      READ: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = beat_last;
        s_axi_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_rready) begin
          if (beat_last) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next word so it is on rdata the cycle after this beat.
            addr_d   = addr_nxt;
            cnt_d    = cnt_q + 8'd1;
            ram_addr = addr_nxt;
            ram_rd   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
    end
  end

  assign s_axi_bid = id_q;
  assign s_axi_rid = id_q;

  cmn_ram #(.DW(32), .AW(DEPTH_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (ram_addr),
    .be_i    (ram_be),
    .wdata_i (s_axi_wdata),
    .rd_en_i (ram_rd),
    .rdata_o (s_axi_rdata)
  );
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: table-driven single transfers plus
// hand sequences for bursts, stalls, errors, contention and mid-burst reset.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ID_W = 4, ADDR_W = 32, DEPTH_W = 10, DEPTH = 1 << DEPTH_W, EW = 40;

  logic clk = 1'b0, rst = 1'b1;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;

  always #5 clk = ~clk;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int checks = 0, errors = 0;
  logic [31:0] model [DEPTH];
  // Read entries: {id[39:36], resp[35:34], last[33], check_data[32], data[31:0]}
  logic [EW-1:0] exp_q[$];
  logic [ID_W+1:0] exp_b_q[$];

  typedef struct {
    logic [31:0] wa;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[DEPTH_W+1:2]);
  endfunction

  task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n; logic ok;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); ok = awready; @(posedge clk); #1; n++; end while (!ok && n < 50);
    awvalid = 1'b0;
    if (!ok) tmo("aw_hs");
  endtask

  task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n; logic ok;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); ok = arready; @(posedge clk); #1; n++; end while (!ok && n < 50);
    arvalid = 1'b0;
    if (!ok) tmo("ar_hs");
  endtask

  task automatic w_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [31:0] base, input logic [3:0] strb, input int early);
    int n, w; logic ok, lastv, err_sofar, err_all;
    err_all = (size != SIZE_WORD) || (burst == BURST_WRAP) || (early >= 0 && early != int'(len));
    exp_b_q.push_back({id, err_all ? RESP_SLVERR : RESP_OKAY});
    err_sofar = (size != SIZE_WORD) || (burst == BURST_WRAP);
    w = widx(addr);
    for (int i = 0; i <= int'(len); i++) begin
      lastv = (early >= 0) ? (i == early) : (i == int'(len));
      if (lastv != (i == int'(len))) err_sofar = 1'b1;
      wdata = base + 32'(i); wstrb = strb; wlast = lastv; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); ok = wready; @(posedge clk); #1; n++; end while (!ok && n < 50);
      if (!ok) begin tmo("w_hs"); wvalid = 1'b0; return; end
      if (i == 0) check("wready_latency", 64'(n), 64'd1);
      if (!err_sofar)
        for (int b = 0; b < 4; b++) if (strb[b]) model[w][b*8 +: 8] = wdata[b*8 +: 8];
      if (burst != BURST_FIXED) w = (w + 1) % DEPTH;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase();
    int n; logic ok; logic [ID_W+1:0] e;
    bready = 1'b1; n = 0;
    do begin
      @(negedge clk); ok = bvalid;
      if (ok) begin
        if (exp_b_q.size() == 0) tmo("b_unexpected");
        else begin
          e = exp_b_q.pop_front();
          check("bresp", 64'(bresp), 64'(e[1:0]));
          check("bid", 64'(bid), 64'(e[ID_W+1:2]));
        end
      end
      @(posedge clk); #1; n++;
    end while (!ok && n < 50);
    bready = 1'b0;
    if (!ok) tmo("b_hs");
    else check("bvalid_latency", 64'(n), 64'd1);
  endtask

  // Consumes stop_after beats; with push set, expectations come from the model.
  task automatic r_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit toggle, input int stop_after, input bit push);
    int n, w, beats; logic err, held_v; logic [35:0] held; logic [EW-1:0] e;
    err = (size != SIZE_WORD) || (burst == BURST_WRAP);
    if (push) begin
      w = widx(addr);
      for (int i = 0; i <= int'(len); i++) begin
        exp_q.push_back({id, err ? RESP_SLVERR : RESP_OKAY, 1'(i == int'(len)), !err, model[w]});
        if (burst != BURST_FIXED) w = (w + 1) % DEPTH;
      end
    end
    rready = !toggle; n = 0; beats = 0; held_v = 1'b0; held = '0;
    while (beats < stop_after && n < 200) begin
      @(negedge clk);
      if (n == 0) check("rvalid_latency", 64'(rvalid), 64'd1);
      if (held_v) check("r_hold", 64'({rvalid, rdata, rlast, rresp}), 64'(held));
      held_v = 1'b0;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) tmo("r_unexpected");
        else begin
          e = exp_q.pop_front();
          if (e[32]) check("rdata", 64'(rdata), 64'(e[31:0]));
          check("rlast", 64'(rlast), 64'(e[33]));
          check("rresp", 64'(rresp), 64'(e[35:34]));
          check("rid", 64'(rid), 64'(e[39:36]));
        end
        beats++;
      end else if (rvalid) begin
        held = {rvalid, rdata, rlast, rresp};
        held_v = 1'b1;
      end
      @(posedge clk); #1; n++;
      if (toggle) rready = ~rready;
    end
    rready = 1'b0;
    if (beats < stop_after) tmo("r_beats");
    else if (!toggle && stop_after == int'(len) + 1) check("r_cycles", 64'(n), 64'(int'(len) + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    vecs[0] = '{32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0020, 4'hF, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF};
    vecs[2] = '{32'h0000_0020, 4'h5, 32'h0000_0000, 32'h0000_0020, 32'hFF00_FF00};
    vecs[3] = '{32'h0000_0024, 4'hF, 32'h1234_5678, 32'h0000_0024, 32'h1234_5678};
    vecs[4] = '{32'h0000_0024, 4'hA, 32'hAABB_CCDD, 32'h0000_0024, 32'hAA34_CC78};
    vecs[5] = '{32'h0000_1010, 4'hF, 32'h0A0B_0C0D, 32'h0000_0010, 32'h0A0B_0C0D};
    vecs[6] = '{32'h0000_0FFC, 4'hF, 32'h5555_AAAA, 32'h0000_0FFC, 32'h5555_AAAA};

    // Reset values, with a competing AW valid to show readies stay low in reset.
    repeat (3) @(posedge clk);
    #1 awvalid = 1'b1;
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_resp", 64'({bresp, rresp}), 64'd0);
    check("rst_ids", 64'({bid, rid}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    awvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      aw_phase(4'(i), vecs[i].wa, 8'd0, SIZE_WORD, BURST_INCR);
      w_phase(4'(i), vecs[i].wa, 8'd0, SIZE_WORD, BURST_INCR, vecs[i].wd, vecs[i].strb, -1);
      b_phase();
      exp_q.push_back({4'(i), RESP_OKAY, 1'b1, 1'b1, vecs[i].exp});
      ar_phase(4'(i), vecs[i].ra, 8'd0, SIZE_WORD, BURST_INCR);
      r_phase(4'(i), vecs[i].ra, 8'd0, SIZE_WORD, BURST_INCR, 1'b0, 1, 1'b0);
    end

    // INCR burst wrapping past the top of memory, read back with and without stalls.
    aw_phase(4'h1, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR);
    w_phase(4'h1, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR, 32'hB000_0000, 4'hF, -1);
    b_phase();
    ar_phase(4'h2, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR);
    r_phase(4'h2, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR, 1'b1, 8, 1'b1);
    ar_phase(4'h3, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR);
    r_phase(4'h3, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR, 1'b0, 8, 1'b1);

    // FIXED burst: every beat lands on the same word.
    aw_phase(4'h4, 32'h0000_0200, 8'd2, SIZE_WORD, BURST_FIXED);
    w_phase(4'h4, 32'h0000_0200, 8'd2, SIZE_WORD, BURST_FIXED, 32'h0F00_0000, 4'hF, -1);
    b_phase();
    ar_phase(4'h4, 32'h0000_0200, 8'd1, SIZE_WORD, BURST_INCR);
    r_phase(4'h4, 32'h0000_0200, 8'd1, SIZE_WORD, BURST_INCR, 1'b0, 2, 1'b1);

    // Bad size on write: SLVERR and memory untouched.
    aw_phase(4'h5, 32'h0000_0010, 8'd0, 3'd1, BURST_INCR);
    w_phase(4'h5, 32'h0000_0010, 8'd0, 3'd1, BURST_INCR, 32'h0000_0BAD, 4'hF, -1);
    b_phase();
    ar_phase(4'h5, 32'h0000_0010, 8'd0, SIZE_WORD, BURST_INCR);
    r_phase(4'h5, 32'h0000_0010, 8'd0, SIZE_WORD, BURST_INCR, 1'b0, 1, 1'b1);

    // WRAP read: four SLVERR beats.
    ar_phase(4'h6, 32'h0000_0040, 8'd3, SIZE_WORD, BURST_WRAP);
    r_phase(4'h6, 32'h0000_0040, 8'd3, SIZE_WORD, BURST_WRAP, 1'b0, 4, 1'b1);

    // Early wlast: words after the bad beat keep their old contents.
    aw_phase(4'h7, 32'h0000_0080, 8'd3, SIZE_WORD, BURST_INCR);
    w_phase(4'h7, 32'h0000_0080, 8'd3, SIZE_WORD, BURST_INCR, 32'hC000_0000, 4'hF, -1);
    b_phase();
    aw_phase(4'h8, 32'h0000_0080, 8'd3, SIZE_WORD, BURST_INCR);
    w_phase(4'h8, 32'h0000_0080, 8'd3, SIZE_WORD, BURST_INCR, 32'hD000_0000, 4'hF, 2);
    b_phase();
    ar_phase(4'h8, 32'h0000_0088, 8'd1, SIZE_WORD, BURST_INCR);
    r_phase(4'h8, 32'h0000_0088, 8'd1, SIZE_WORD, BURST_INCR, 1'b0, 2, 1'b1);

    // Contention from a fresh reset: grants go W, R, W.
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    awid = 4'h7; awaddr = 32'h100; awlen = 8'd0; awsize = SIZE_WORD; awburst = BURST_INCR; awvalid = 1'b1;
    arid = 4'h8; araddr = 32'h100; arlen = 8'd0; arsize = SIZE_WORD; arburst = BURST_INCR; arvalid = 1'b1;
    @(negedge clk);
    check("tie1_awready", 64'(awready), 64'd1);
    check("tie1_arready", 64'(arready), 64'd0);
    @(posedge clk); #1 awvalid = 1'b0;
    w_phase(4'h7, 32'h100, 8'd0, SIZE_WORD, BURST_INCR, 32'h7777_0001, 4'hF, -1);
    b_phase();
    awid = 4'h9; awaddr = 32'h104; awvalid = 1'b1;
    @(negedge clk);
    check("tie2_awready", 64'(awready), 64'd0);
    check("tie2_arready", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    r_phase(4'h8, 32'h100, 8'd0, SIZE_WORD, BURST_INCR, 1'b0, 1, 1'b1);
    arid = 4'hA; araddr = 32'h104; arvalid = 1'b1;
    @(negedge clk);
    check("tie3_awready", 64'(awready), 64'd1);
    check("tie3_arready", 64'(arready), 64'd0);
    @(posedge clk); #1 awvalid = 1'b0;
    w_phase(4'h9, 32'h104, 8'd0, SIZE_WORD, BURST_INCR, 32'h9999_0002, 4'hF, -1);
    b_phase();
    ar_phase(4'hA, 32'h104, 8'd0, SIZE_WORD, BURST_INCR);
    r_phase(4'hA, 32'h104, 8'd0, SIZE_WORD, BURST_INCR, 1'b0, 1, 1'b1);

    // Reset in the middle of a read burst.
    ar_phase(4'hB, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR);
    r_phase(4'hB, 32'h0000_0FF8, 8'd7, SIZE_WORD, BURST_INCR, 1'b0, 3, 1'b1);
    check("pre_rst_rvalid", 64'(rvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_rlast", 64'(rlast), 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    ar_phase(4'hC, 32'h0000_0020, 8'd0, SIZE_WORD, BURST_INCR);
    r_phase(4'hC, 32'h0000_0020, 8'd0, SIZE_WORD, BURST_INCR, 1'b0, 1, 1'b1);

    check("sb_r_empty", 64'(exp_q.size()), 64'd0);
    check("sb_b_empty", 64'(exp_b_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
